fp_mult_round: RTL and testbench

//  Rounding/exception stage directly downstream of the multiplier normalizer.

---
 rtl/fp_mult_pkg.sv | 22 ++
 rtl/fp_round_decide.sv | 28 ++
 rtl/fp_mult_round.sv | 156 +++++++++++++++
 tb/tb_fp_mult_round.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the multiplier rounding/exception path.
package fp_mult_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RZ  = 3'd1,
    RUP = 3'd2,
    RDN = 3'd3,
    RNA = 3'd4
  } round_mode_t;

  localparam int          FEXP_BITS = 8;
  localparam int          EXP_MAX   = 2**FEXP_BITS - 1;
  localparam logic [31:0] QNAN      = 32'h7FC00000;
  localparam logic [30:0] MAXF      = 31'h7F7FFFFF;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

endpackage

// File: rtl/fp_round_decide.sv
// Combinational round-increment decision from sign, LSB, guard and sticky bits.
module fp_round_decide
  import fp_mult_pkg::*;
(
  input  logic       sign_i,
  input  logic       lsb_i,
  input  logic       guard_i,
  input  logic       sticky_i,
  input  logic [2:0] mode_i,
  output logic       inc_o,
  output logic       inexact_o
);

  // Unrecognised mode encodings truncate, the safest non-increasing choice.
  always_comb begin
    inexact_o = guard_i | sticky_i;
    inc_o     = 1'b0;
    case (mode_i)
      RNE:     inc_o = guard_i & (sticky_i | lsb_i);
      RZ:      inc_o = 1'b0;
      RUP:     inc_o = ~sign_i & (guard_i | sticky_i);
      RDN:     inc_o = sign_i & (guard_i | sticky_i);
      RNA:     inc_o = guard_i;
      default: inc_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_mult_round.sv
// Two-stage rounding/exception pipeline producing packed binary32 plus IEEE flags.
module fp_mult_round
  import fp_mult_pkg::*;
#(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 10,
  parameter int FEXP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_guard,
  input  logic              in_sticky,
  input  logic [2:0]        in_rmode,
  input  logic              in_nan,
  input  logic              in_invalid,
  input  logic              in_inf,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [3:0]        out_flags
);

  localparam logic [EXP_W:0] EXP_LIMIT = (EXP_W+1)'(EXP_MAX);

  logic              adv1, adv2;
  logic              inc, inexact;
  logic [EXP_W-1:0]  exp_d;
  logic [MANT_W:0]   sum_d;

  logic              v1_q;
  logic [MANT_W:0]   sum1_q;
  logic [EXP_W-1:0]  exp1_q;
  logic              sign1_q, tiny1_q, inexact1_q;
  logic [2:0]        mode1_q;
  logic              nan1_q, invalid1_q, inf1_q, zero1_q;

  logic              v2_q;
  logic [31:0]       result_q, result_d;
  logic [3:0]        flags_q, flags_d;

  logic              carry;
  logic [MANT_W-1:0] frac;
  logic [EXP_W:0]    exp_r;

  assign adv2     = ~v2_q | out_ready;
  assign adv1     = ~v1_q | adv2;
  assign in_ready = adv1;

  fp_round_decide u_decide (
    .sign_i    (in_sign),
    .lsb_i     (in_mant[0]),
    .guard_i   (in_guard),
    .sticky_i  (in_sticky),
    .mode_i    (in_rmode),
    .inc_o     (inc),
    .inexact_o (inexact)
  );

  // Negative biased exponents from the normalizer are clamped into the subnormal range.
  always_comb begin
    exp_d = in_exp[EXP_W-1] ? '0 : in_exp;
    sum_d = {1'b0, in_mant} + {{MANT_W{1'b0}}, inc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      sum1_q     <= '0;
      exp1_q     <= '0;
      sign1_q    <= 1'b0;
      tiny1_q    <= 1'b0;
      inexact1_q <= 1'b0;
      mode1_q    <= 3'd0;
      nan1_q     <= 1'b0;
      invalid1_q <= 1'b0;
      inf1_q     <= 1'b0;
      zero1_q    <= 1'b0;
    end else if (adv1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        sum1_q     <= sum_d;
        exp1_q     <= exp_d;
        sign1_q    <= in_sign;
        tiny1_q    <= (exp_d == '0);
        inexact1_q <= inexact;
        mode1_q    <= in_rmode;
        nan1_q     <= in_nan;
        invalid1_q <= in_invalid;
        inf1_q     <= in_inf;
        zero1_q    <= in_zero;
      end
    end
  end

  // A rounding carry leaves an all-zero fraction and bumps the exponent, which also promotes subnormals.
  always_comb begin
    carry = sum1_q[MANT_W];
    frac  = carry ? '0 : sum1_q[MANT_W-1:0];
    exp_r = {1'b0, exp1_q} + {{EXP_W{1'b0}}, carry};
  end

  always_comb begin
    result_d                 = {sign1_q, exp_r[FEXP_W-1:0], frac};
    flags_d                  = '0;
    flags_d[FLAG_UNDERFLOW]  = tiny1_q & inexact1_q;
    flags_d[FLAG_INEXACT]    = inexact1_q;
    if (nan1_q | invalid1_q) begin
      result_d               = QNAN;
      flags_d                = '0;
      flags_d[FLAG_INVALID]  = invalid1_q;
    end else if (inf1_q) begin
      result_d = {sign1_q, {FEXP_W{1'b1}}, {MANT_W{1'b0}}};
      flags_d  = '0;
    end else if (zero1_q) begin
      result_d = {sign1_q, {FEXP_W{1'b0}}, {MANT_W{1'b0}}};
      flags_d  = '0;
    end else if (exp_r >= EXP_LIMIT) begin
      flags_d                 = '0;
      flags_d[FLAG_OVERFLOW]  = 1'b1;
      flags_d[FLAG_INEXACT]   = 1'b1;
      result_d = {sign1_q, {FEXP_W{1'b1}}, {MANT_W{1'b0}}};
      // Directed modes saturate to the largest finite value on the side they round toward zero.
      case (mode1_q)
        RZ:      result_d = {sign1_q, MAXF};
        RUP:     if (sign1_q)  result_d = {1'b1, MAXF};
        RDN:     if (!sign1_q) result_d = {1'b0, MAXF};
        default: result_d = {sign1_q, {FEXP_W{1'b1}}, {MANT_W{1'b0}}};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign out_valid  = v2_q;
  assign out_result = result_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_fp_mult_round.sv
// Directed bench for fp_mult_round: rounding modes, renormalization, exceptions and handshake.
module tb_fp_mult_round;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [22:0] in_mant;
  logic [9:0]  in_exp;
  logic        in_guard;
  logic        in_sticky;
  logic [2:0]  in_rmode;
  logic        in_nan;
  logic        in_invalid;
  logic        in_inf;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] flowExp [4];
  int          sent, got, seen;

  fp_mult_round dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_mant    (in_mant),
    .in_exp     (in_exp),
    .in_guard   (in_guard),
    .in_sticky  (in_sticky),
    .in_rmode   (in_rmode),
    .in_nan     (in_nan),
    .in_invalid (in_invalid),
    .in_inf     (in_inf),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkBit(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic setInputs(input logic s, input logic [9:0] e, input logic [22:0] m,
                           input logic g, input logic st, input logic [2:0] rm,
                           input logic nan, input logic inv, input logic inf, input logic zero);
    in_sign    = s;
    in_exp     = e;
    in_mant    = m;
    in_guard   = g;
    in_sticky  = st;
    in_rmode   = rm;
    in_nan     = nan;
    in_invalid = inv;
    in_inf     = inf;
    in_zero    = zero;
  endtask

  task automatic applyStimulus(input logic s, input logic [9:0] e, input logic [22:0] m,
                               input logic g, input logic st, input logic [2:0] rm,
                               input logic nan, input logic inv, input logic inf, input logic zero);
    @(negedge clk);
    setInputs(s, e, m, g, st, rm, nan, inv, inf, zero);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expRes, input logic [3:0] expFlags);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkBit({tag, " valid"}, found, 1'b1);
    if (found) begin
      checkWord({tag, " result"}, out_result, expRes);
      checkWord({tag, " flags"}, {28'd0, out_flags}, {28'd0, expFlags});
    end
  endtask

  task automatic setFlowBeat(input int i);
    setInputs(1'b0, 10'(127 + i), 23'(i), 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    setInputs(1'b0, 10'd0, 23'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) flowExp[i] = {1'b0, 8'd127 + 8'(i), 23'(i)};

    repeat (3) @(negedge clk);
    #1;
    checkBit("reset out_valid", out_valid, 1'b0);
    checkWord("reset out_result", out_result, 32'h0);
    checkWord("reset out_flags", {28'd0, out_flags}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkBit("in_ready after reset", in_ready, 1'b1);

    // rmode encodings: 0 RNE, 1 RZ, 2 RUP, 3 RDN, 4 RNA
    applyStimulus(1'b0, 10'd127, 23'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rne tie even", 32'h3F800000, 4'b0001);
    applyStimulus(1'b0, 10'd127, 23'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rne tie odd", 32'h3F800002, 4'b0001);
    applyStimulus(1'b0, 10'd127, 23'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rne tie odd 3", 32'h3F800004, 4'b0001);
    applyStimulus(1'b0, 10'd127, 23'h7FFFFF, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("carry renorm", 32'h40000000, 4'b0001);
    applyStimulus(1'b0, 10'd127, 23'd0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rna tie", 32'h3F800001, 4'b0001);
    applyStimulus(1'b0, 10'd127, 23'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rup pos", 32'h3F800001, 4'b0001);
    applyStimulus(1'b1, 10'd127, 23'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rdn neg", 32'hBF800001, 4'b0001);
    applyStimulus(1'b0, 10'd127, 23'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rdn pos", 32'h3F800000, 4'b0001);

    applyStimulus(1'b0, 10'd254, 23'h7FFFFF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf rne", 32'h7F800000, 4'b0101);
    applyStimulus(1'b0, 10'd254, 23'h7FFFFF, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rz near max", 32'h7F7FFFFF, 4'b0001);
    applyStimulus(1'b0, 10'd255, 23'd0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf rz", 32'h7F7FFFFF, 4'b0101);
    applyStimulus(1'b1, 10'd254, 23'h7FFFFF, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rup neg near max", 32'hFF7FFFFF, 4'b0001);
    applyStimulus(1'b1, 10'd300, 23'd0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf rup neg", 32'hFF7FFFFF, 4'b0101);
    applyStimulus(1'b0, 10'd300, 23'd0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf rdn pos", 32'h7F7FFFFF, 4'b0101);
    applyStimulus(1'b1, 10'd300, 23'd0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf rdn neg", 32'hFF800000, 4'b0101);

    applyStimulus(1'b0, 10'd0, 23'h7FFFFF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("subnormal carry", 32'h00800000, 4'b0011);
    applyStimulus(1'b0, 10'd0, 23'd5, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("subnormal exact", 32'h00000005, 4'b0000);
    applyStimulus(1'b0, 10'h3FD, 23'd5, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("negative exp", 32'h00000005, 4'b0011);

    applyStimulus(1'b0, 10'd127, 23'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("invalid", 32'h7FC00000, 4'b1000);
    applyStimulus(1'b1, 10'd127, 23'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("nan over inf", 32'h7FC00000, 4'b0000);
    applyStimulus(1'b1, 10'd127, 23'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("inf neg", 32'hFF800000, 4'b0000);
    applyStimulus(1'b1, 10'd127, 23'd9, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("zero neg", 32'h80000000, 4'b0000);

    // Stall with two beats held, then drain all four in order.
    @(negedge clk);
    out_ready = 1'b0;
    setFlowBeat(0);
    in_valid = 1'b1;
    @(negedge clk);
    setFlowBeat(1);
    @(negedge clk);
    setFlowBeat(2);
    #1;
    checkBit("stall in_ready", in_ready, 1'b0);
    checkBit("stall out_valid", out_valid, 1'b1);
    checkWord("stall head", out_result, flowExp[0]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checkWord("stall stable", out_result, flowExp[0]);
      checkBit("stall in_ready held", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    sent = 2;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      #1;
      if (out_valid) begin
        checkWord("drain order", out_result, flowExp[got]);
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
      if (sent < 4) setFlowBeat(sent);
      else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checkWord("drain count", 32'(got), 32'd4);

    // Reset while stalled discards everything in flight.
    @(negedge clk);
    out_ready = 1'b0;
    setFlowBeat(0);
    in_valid = 1'b1;
    @(negedge clk);
    setFlowBeat(1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkBit("pre-reset held", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    checkBit("reset flush valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen      = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    checkWord("post-reset deliveries", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
